// File: rtl/line_unpacker.sv
// line_unpacker
//   Read-side counterpart to the horizontal-sync pixel packer. It takes one
//   packed line of PIXELS 24-bit pixels in a single load handshake. It then
//   streams the pixels out one per accepted beat as separate R/G/B bytes. The
//   oldest pixel, held in the most-significant slot, is sent first. hsync is
//   high while the line is being streamed. After the last pixel, hsync is
//   held low for BLANK_CYCLES cycles before the next line can be loaded.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   bufferin     packed line, per pixel B[23:16] G[15:8] R[7:0], oldest in MS slot
//   load_valid   bufferin holds a complete line
//   load_ready   block can capture a line (IDLE, not in reset)
//   R, G, B      current pixel bytes, taken straight from the top slot
//   pixel_valid  R/G/B hold a valid pixel (ACTIVE)
//   pixel_ready  downstream accepts the pixel this cycle
//   hsync        high for the whole active line
//   line_done    one-cycle pulse on the cycle the last pixel is accepted
module line_unpacker #(
  parameter int PIXELS       = 8,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [24*PIXELS-1:0] bufferin,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic [7:0]           R,
  output logic [7:0]           G,
  output logic [7:0]           B,
  output logic                 pixel_valid,
  input  logic                 pixel_ready,
  output logic                 hsync,
  output logic                 line_done
);

  localparam int W   = 24 * PIXELS;
  localparam int PCW = $clog2(PIXELS + 1);
  // Keep the blank counter at least one bit wide so BLANK_CYCLES=0 still elaborates.
  localparam int BCW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [W-1:0]     sr_reg;
  logic [PCW-1:0]   pix_cnt_reg;
  logic [BCW-1:0]   blank_cnt_reg;
  logic             last_beat;

  assign last_beat = (state_reg == ACTIVE) && pixel_ready && (pix_cnt_reg == PCW'(1));

  // The control outputs come straight from the state register. load_ready and
  // line_done are also masked by rst. This keeps a handshake from being
  // offered, and a line end from being reported, during the reset cycle.
  assign load_ready  = (state_reg == IDLE) && !rst;
  assign pixel_valid = (state_reg == ACTIVE);
  assign hsync       = (state_reg == ACTIVE);
  assign line_done   = last_beat && !rst;

  // The register empties to zero as the line is shifted out, so the colour
  // bytes read zero outside ACTIVE.
  assign B = sr_reg[W-1  -: 8];
  assign G = sr_reg[W-9  -: 8];
  assign R = sr_reg[W-17 -: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sr_reg        <= '0;
      pix_cnt_reg   <= '0;
      blank_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load_valid) begin
            sr_reg      <= bufferin;
            pix_cnt_reg <= PCW'(PIXELS);
            state_reg   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (pixel_ready) begin
            sr_reg      <= {sr_reg[W-25:0], 24'h000000};
            pix_cnt_reg <= pix_cnt_reg - PCW'(1);
            if (pix_cnt_reg == PCW'(1)) begin
              if (BLANK_CYCLES > 0) begin
                blank_cnt_reg <= BCW'(BLANK_CYCLES);
                state_reg     <= BLANK;
              end else begin
                state_reg <= IDLE;
              end
            end
          end
        end
        BLANK: begin
          // The count is loaded with BLANK_CYCLES on entry. Leaving when it
          // reads 1 gives exactly BLANK_CYCLES cycles in this state.
          if (blank_cnt_reg <= BCW'(1)) begin
            blank_cnt_reg <= '0;
            state_reg     <= IDLE;
          end else begin
            blank_cnt_reg <= blank_cnt_reg - BCW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_unpacker.sv
module tb_line_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // u0: PIXELS=4, BLANK_CYCLES=2
  logic        rst0, load_valid0, load_ready0, pixel_valid0, pixel_ready0, hsync0, line_done0;
  logic [95:0] bufferin0;
  logic [7:0]  r0, g0, b0;
  // u1: PIXELS=4, BLANK_CYCLES=0
  logic        rst1, load_valid1, load_ready1, pixel_valid1, pixel_ready1, hsync1, line_done1;
  logic [95:0] bufferin1;
  logic [7:0]  r1, g1, b1;

  line_unpacker #(.PIXELS(4), .BLANK_CYCLES(2)) u0 (
    .clk(clk), .rst(rst0), .bufferin(bufferin0), .load_valid(load_valid0),
    .load_ready(load_ready0), .R(r0), .G(g0), .B(b0), .pixel_valid(pixel_valid0),
    .pixel_ready(pixel_ready0), .hsync(hsync0), .line_done(line_done0)
  );

  line_unpacker #(.PIXELS(4), .BLANK_CYCLES(0)) u1 (
    .clk(clk), .rst(rst1), .bufferin(bufferin1), .load_valid(load_valid1),
    .load_ready(load_ready1), .R(r1), .G(g1), .B(b1), .pixel_valid(pixel_valid1),
    .pixel_ready(pixel_ready1), .hsync(hsync1), .line_done(line_done1)
  );

  int checks   = 0;
  int failures = 0;

  logic [23:0] exp_pix [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Runs one line on u0, starting from IDLE. It may stall the beat
  // stall_beat for stall_len cycles. With poke set, load_valid is held high
  // with a different bufferin while the line is active.
  task automatic run_u0_line(input string tag, input logic [95:0] line,
                             input int stall_beat, input int stall_len, input bit poke);
    int beat, stalls, active;
    logic rdy;
    step();
    load_valid0 = 1'b1; bufferin0 = line; pixel_ready0 = 1'b1;
    #1;
    check({tag, "_ld_ready"}, 32'(load_ready0), 32'd1);
    check({tag, "_idle_valid"}, 32'(pixel_valid0), 32'd0);
    beat = 0; stalls = 0; active = 0;
    step();
    load_valid0 = poke;
    if (poke) bufferin0 = ~line;
    while (beat < 4 && active < 40) begin
      rdy = !(beat == stall_beat && stalls < stall_len);
      pixel_ready0 = rdy;
      #1;
      check({tag, "_valid"}, 32'(pixel_valid0), 32'd1);
      check({tag, "_hsync"}, 32'(hsync0), 32'd1);
      check({tag, "_busy_ld_ready"}, 32'(load_ready0), 32'd0);
      check({tag, "_pix"}, 32'({b0, g0, r0}), 32'(exp_pix[beat]));
      check({tag, "_line_done"}, 32'(line_done0), 32'(rdy && beat == 3));
      active++;
      if (rdy) beat++; else stalls++;
      step();
    end
    load_valid0 = 1'b0; pixel_ready0 = 1'b0;
    check({tag, "_beats"}, 32'(beat), 32'd4);
    check({tag, "_active_cycles"}, 32'(active), 32'(4 + stall_len));
    for (int i = 0; i < 2; i++) begin
      #1;
      check({tag, "_blank_hsync"}, 32'(hsync0), 32'd0);
      check({tag, "_blank_valid"}, 32'(pixel_valid0), 32'd0);
      check({tag, "_blank_ld_ready"}, 32'(load_ready0), 32'd0);
      check({tag, "_blank_line_done"}, 32'(line_done0), 32'd0);
      step();
    end
    #1;
    check({tag, "_post_ld_ready"}, 32'(load_ready0), 32'd1);
    $display("line %s: %0d active cycles, %0d beats", tag, active, beat);
  endtask

  logic [95:0] lbasic, la, lb, lrt;
  logic [23:0] b2b_pix [8];
  logic [23:0] rt_pix [4];
  bit          exp_v, exp_lr, exp_ld;
  int          bi;

  initial begin
    rst0 = 1'b1; load_valid0 = 1'b0; bufferin0 = '0; pixel_ready0 = 1'b0;
    rst1 = 1'b1; load_valid1 = 1'b0; bufferin1 = '0; pixel_ready1 = 1'b0;
    lbasic = 96'h010203_040506_070809_0A0B0C;

    // Reset state
    step(); step();
    #1;
    check("rst_ld_ready", 32'(load_ready0), 32'd0);
    check("rst_valid", 32'(pixel_valid0), 32'd0);
    check("rst_hsync", 32'(hsync0), 32'd0);
    check("rst_line_done", 32'(line_done0), 32'd0);
    check("rst_rgb", 32'({b0, g0, r0}), 32'd0);
    check("rst_u1_ld_ready", 32'(load_ready1), 32'd0);
    step();
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    check("idle_ld_ready", 32'(load_ready0), 32'd1);
    check("idle_u1_ld_ready", 32'(load_ready1), 32'd1);

    // Basic line
    exp_pix[0] = 24'h010203; exp_pix[1] = 24'h040506;
    exp_pix[2] = 24'h070809; exp_pix[3] = 24'h0A0B0C;
    run_u0_line("basic", lbasic, -1, 0, 1'b0);

    // Backpressure: beat 2 (index 1) stalled for 3 cycles
    run_u0_line("stall", lbasic, 1, 3, 1'b0);

    // Load attempt while busy must be ignored
    run_u0_line("busy", lbasic, -1, 0, 1'b1);

    // Reset mid-line after 2 of 4 pixels
    step();
    load_valid0 = 1'b1; bufferin0 = lbasic; pixel_ready0 = 1'b1;
    step();
    load_valid0 = 1'b0;
    #1;
    check("mid_pix0", 32'({b0, g0, r0}), 32'h010203);
    step();
    #1;
    check("mid_pix1", 32'({b0, g0, r0}), 32'h040506);
    step();
    rst0 = 1'b1;
    #1;
    check("mid_rst_line_done", 32'(line_done0), 32'd0);
    check("mid_rst_ld_ready", 32'(load_ready0), 32'd0);
    step();
    #1;
    check("mid_after_hsync", 32'(hsync0), 32'd0);
    check("mid_after_valid", 32'(pixel_valid0), 32'd0);
    check("mid_after_line_done", 32'(line_done0), 32'd0);
    check("mid_after_rgb", 32'({b0, g0, r0}), 32'd0);
    step();
    rst0 = 1'b0; pixel_ready0 = 1'b0;
    #1;
    check("mid_release_ld_ready", 32'(load_ready0), 32'd1);
    check("mid_release_line_done", 32'(line_done0), 32'd0);
    $display("line midreset: abandoned after 2 beats");

    // Round trip: the packer shifts each new pixel in at the LS end
    rt_pix[0] = 24'h1F2E3D; rt_pix[1] = 24'h4C5B6A;
    rt_pix[2] = 24'h798897; rt_pix[3] = 24'hA6B5C4;
    lrt = '0;
    for (int i = 0; i < 4; i++) lrt = {lrt[71:0], rt_pix[i]};
    for (int i = 0; i < 4; i++) exp_pix[i] = rt_pix[i];
    run_u0_line("roundtrip", lrt, -1, 0, 1'b0);

    // Back-to-back lines on u1 (no blanking), with load_valid held high
    la = 96'h112233_445566_778899_AABBCC;
    lb = 96'hD0D1D2_E0E1E2_F0F1F2_C0C1C2;
    b2b_pix[0] = 24'h112233; b2b_pix[1] = 24'h445566;
    b2b_pix[2] = 24'h778899; b2b_pix[3] = 24'hAABBCC;
    b2b_pix[4] = 24'hD0D1D2; b2b_pix[5] = 24'hE0E1E2;
    b2b_pix[6] = 24'hF0F1F2; b2b_pix[7] = 24'hC0C1C2;
    step();
    load_valid1 = 1'b1; bufferin1 = la; pixel_ready1 = 1'b1;
    bi = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) bufferin1 = lb;
      if (c == 10) load_valid1 = 1'b0;
      exp_v  = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
      exp_lr = (c == 0) || (c == 5) || (c >= 10);
      exp_ld = (c == 4) || (c == 9);
      #1;
      check("b2b_valid", 32'(pixel_valid1), 32'(exp_v));
      check("b2b_hsync", 32'(hsync1), 32'(exp_v));
      check("b2b_ld_ready", 32'(load_ready1), 32'(exp_lr));
      check("b2b_line_done", 32'(line_done1), 32'(exp_ld));
      if (exp_v) begin
        check("b2b_pix", 32'({b1, g1, r1}), 32'(b2b_pix[bi]));
        bi++;
      end
      step();
    end
    $display("line b2b: two lines, period 5 cycles");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
